// File: rtl/pim_matmul_engine_pkg.sv
// Shared types and sizing constants for the PIM matrix-multiply engine.
package pim_matmul_engine_pkg;

  localparam int WIDTH        = 8;
  localparam int MATRIX_SIZE  = 2;
  localparam int LEN          = MATRIX_SIZE * MATRIX_SIZE;
  localparam int MEM_ELEMENTS = 64;

  // Width of a counter that must hold values 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CNT_W = cnt_width(MATRIX_SIZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } pim_state_t;

endpackage

// File: rtl/pim_matmul_engine_mac_unit.sv
// Single multiply-accumulate stage: acc_next = acc + a*b, modulo 2^DATA_W.
module pim_mac_unit #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] acc_next_o,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;

  // Truncated multiply-add; the DATA_W-wide context drops the upper product bits.
  always_comb begin
    acc_next_o = acc_q + a_i * b_i;
  end

  // Accumulator register; clear has priority so the final MAC of a dot product
  // leaves the accumulator empty for the next element.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_next_o;
    end else begin
      acc_q <= acc_q;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pim_matmul_engine.sv
// PIM responder: latches two N x N row-major operands on start, computes
// C = A x B with one MAC per cycle, then pulses result_ready for one cycle.
module pim_matmul_engine
  import pim_matmul_engine_pkg::*;
#(
  parameter int DATA_W = WIDTH,
  parameter int N      = MATRIX_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] matrix_A [N*N],
  input  logic [DATA_W-1:0] matrix_B [N*N],
  output logic [DATA_W-1:0] result   [N*N],
  output logic              result_ready,
  output logic              busy
);

  localparam int NN    = N * N;
  localparam int CW    = cnt_width(N);
  localparam int IDX_W = cnt_width(NN);

  pim_state_t        state_q, state_d;
  logic [CW-1:0]     row_q, row_d, col_q, col_d, k_q, k_d;
  logic [DATA_W-1:0] op_a_q   [NN];
  logic [DATA_W-1:0] op_b_q   [NN];
  logic [DATA_W-1:0] result_q [NN];
  logic              busy_q, ready_q;

  logic              accept_s, last_k_s, last_col_s, last_row_s;
  logic              mac_en_s, mac_clr_s, write_s;
  logic [IDX_W-1:0]  idx_a_s, idx_b_s, idx_c_s;
  logic [DATA_W-1:0] mac_a_s, mac_b_s, acc_next_s, acc_s;

  // Operand/result addressing from the row, column and inner-product counters.
  always_comb begin
    last_k_s   = (k_q   == CW'(N - 1));
    last_col_s = (col_q == CW'(N - 1));
    last_row_s = (row_q == CW'(N - 1));
    idx_a_s    = IDX_W'(int'(row_q) * N + int'(k_q));
    idx_b_s    = IDX_W'(int'(k_q) * N + int'(col_q));
    idx_c_s    = IDX_W'(int'(row_q) * N + int'(col_q));
    mac_a_s    = op_a_q[idx_a_s];
    mac_b_s    = op_b_q[idx_b_s];
  end

  // Next-state logic; start is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    state_d  = state_q;
    accept_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COMPUTE;
          accept_s = 1'b1;
        end else begin
          state_d  = IDLE;
        end
      end
      COMPUTE: begin
        if (last_k_s && last_col_s && last_row_s) begin
          state_d = DONE;
        end else begin
          state_d = COMPUTE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MAC control: accumulate every COMPUTE cycle, write and clear on the last k.
  always_comb begin
    mac_en_s  = (state_q == COMPUTE);
    write_s   = mac_en_s && last_k_s;
    mac_clr_s = accept_s || write_s;
  end

  // Counter sequencing: k innermost, then column, then row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    k_d   = k_q;
    if (accept_s) begin
      row_d = '0;
      col_d = '0;
      k_d   = '0;
    end else if (mac_en_s) begin
      if (last_k_s) begin
        k_d = '0;
        if (last_col_s) begin
          col_d = '0;
          if (last_row_s) begin
            row_d = '0;
          end else begin
            row_d = row_q + CW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end else begin
        k_d = k_q + CW'(1);
      end
    end else begin
      k_d = k_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Loop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
      k_q   <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      k_q   <= k_d;
    end
  end

  // Operand snapshot taken only on the accepting edge; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NN; i++) begin
        op_a_q[i] <= '0;
        op_b_q[i] <= '0;
      end
    end else if (accept_s) begin
      for (int i = 0; i < NN; i++) begin
        op_a_q[i] <= matrix_A[i];
        op_b_q[i] <= matrix_B[i];
      end
    end else begin
      for (int i = 0; i < NN; i++) begin
        op_a_q[i] <= op_a_q[i];
        op_b_q[i] <= op_b_q[i];
      end
    end
  end

  // Result array: each element is written once at its final k and then held.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NN; i++) begin
        result_q[i] <= '0;
      end
    end else if (write_s) begin
      result_q[idx_c_s] <= acc_next_s;
    end else begin
      result_q[idx_c_s] <= result_q[idx_c_s];
    end
  end

  // Status flags registered from the state register, so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      busy_q  <= (state_q != IDLE);
      ready_q <= (state_q == DONE);
    end
  end

  pim_mac_unit #(
    .DATA_W(DATA_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (mac_clr_s),
    .en_i      (mac_en_s),
    .a_i       (mac_a_s),
    .b_i       (mac_b_s),
    .acc_next_o(acc_next_s),
    .acc_o     (acc_s)
  );

  assign result       = result_q;
  assign result_ready = ready_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_pim_matmul_engine.sv
// Self-checking bench for pim_matmul_engine with N=2, DATA_W=8.
module tb_pim_matmul_engine;

  localparam int DW = 8;
  localparam int NB = 2;

  typedef logic [0:3][7:0] mat_t;

  typedef struct packed {
    mat_t a;
    mat_t b;
    mat_t expv;
    logic [1:0] mode;   // 0 plain, 1 start collision, 2 reset mid-compute, 3 operand change
    mat_t alt_a;
    mat_t alt_b;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] mA  [NB*NB];
  logic [DW-1:0] mB  [NB*NB];
  logic [DW-1:0] res [NB*NB];
  logic          result_ready;
  logic          busy;

  int   n_pass = 0;
  int   n_total = 0;
  mat_t last_res;
  vec_t tbl [8];

  pim_matmul_engine #(.DATA_W(DW), .N(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .matrix_A    (mA),
    .matrix_B    (mB),
    .result      (res),
    .result_ready(result_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic mat_t m4(input int x0, input int x1, input int x2, input int x3);
    mat_t m;
    m[0] = 8'(x0); m[1] = 8'(x1); m[2] = 8'(x2); m[3] = 8'(x3);
    return m;
  endfunction

  function automatic vec_t mk(input mat_t a, input mat_t b, input mat_t e,
                              input int mode, input mat_t aa, input mat_t ab);
    vec_t v;
    v.a = a; v.b = b; v.expv = e; v.mode = 2'(mode); v.alt_a = aa; v.alt_b = ab;
    return v;
  endfunction

  // Reference: textbook matrix product, reduced modulo 256.
  function automatic mat_t model(input mat_t a, input mat_t b);
    mat_t c;
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NB; j++) begin
        int s = 0;
        for (int k = 0; k < NB; k++) s += int'(a[i*NB+k]) * int'(b[k*NB+j]);
        c[i*NB+j] = 8'(s % 256);
      end
    return c;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  task automatic drive(input mat_t a, input mat_t b);
    for (int i = 0; i < NB*NB; i++) begin
      mA[i] = a[i];
      mB[i] = b[i];
    end
  endtask

  // One job: start sampled at edge 0, then 12 observed edges with optional disturbance.
  task automatic run_job(input string nm, input vec_t v);
    int ready_cnt = 0;
    int ready_e   = -1;
    int busy_err  = 0;
    int held_err  = 0;
    mat_t want;
    drive(v.a, v.b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (result_ready) begin
        ready_cnt++;
        if (ready_e < 0) ready_e = e;
      end
      if (busy !== ((v.mode == 2'd2) ? (e < 5) : (e <= 9))) busy_err++;
      if (e == 1)
        for (int i = 0; i < NB*NB; i++) if (res[i] !== last_res[i]) held_err++;
      if (v.mode == 2'd1 && e == 3) begin drive(v.alt_a, v.alt_b); start = 1'b1; end
      if (v.mode == 2'd1 && e == 4) start = 1'b0;
      if (v.mode == 2'd2 && e == 4) rst = 1'b1;
      if (v.mode == 2'd2 && e == 5) rst = 1'b0;
      if (v.mode == 2'd3 && e == 1) drive(v.alt_a, v.b);
    end
    want = (v.mode == 2'd2) ? m4(0, 0, 0, 0) : v.expv;
    chk({nm, " held"}, held_err, 0);
    chk({nm, " busy"}, busy_err, 0);
    chk({nm, " ready_cnt"}, ready_cnt, (v.mode == 2'd2) ? 0 : 1);
    if (v.mode != 2'd2) chk({nm, " ready_edge"}, ready_e, 9);
    for (int i = 0; i < NB*NB; i++)
      chk($sformatf("%s C[%0d]", nm, i), int'(res[i]), int'(want[i]));
    last_res = want;
  endtask

  initial begin
    mat_t ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    drive(m4(0, 0, 0, 0), m4(0, 0, 0, 0));
    last_res = m4(0, 0, 0, 0);

    tbl[0] = mk(m4(1,2,3,4),         m4(5,6,7,8),         m4(19,22,43,50), 0, m4(0,0,0,0), m4(0,0,0,0));
    tbl[1] = mk(m4(1,0,0,1),         m4(9,8,7,6),         m4(9,8,7,6),     0, m4(0,0,0,0), m4(0,0,0,0));
    tbl[2] = mk(m4(2,0,0,2),         m4(9,8,7,6),         m4(18,16,14,12), 0, m4(0,0,0,0), m4(0,0,0,0));
    tbl[3] = mk(m4(255,255,255,255), m4(255,255,255,255), m4(2,2,2,2),     0, m4(0,0,0,0), m4(0,0,0,0));
    tbl[4] = mk(m4(1,2,3,4),         m4(5,6,7,8),         m4(19,22,43,50), 1, m4(3,3,3,3), m4(7,1,7,1));
    tbl[5] = mk(m4(1,2,3,4),         m4(5,6,7,8),         m4(19,22,43,50), 2, m4(0,0,0,0), m4(0,0,0,0));
    tbl[6] = mk(m4(1,2,3,4),         m4(5,6,7,8),         m4(19,22,43,50), 0, m4(0,0,0,0), m4(0,0,0,0));
    tbl[7] = mk(m4(1,2,3,4),         m4(5,6,7,8),         m4(19,22,43,50), 3, m4(9,9,9,9), m4(0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset busy", int'(busy), 0);
    chk("reset ready", int'(result_ready), 0);
    for (int i = 0; i < NB*NB; i++) chk($sformatf("reset C[%0d]", i), int'(res[i]), 0);

    for (int t = 0; t < 8; t++) run_job($sformatf("vec%0d", t), tbl[t]);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < NB*NB; i++) begin
        ra[i] = 8'($urandom_range(0, 255));
        rb[i] = 8'($urandom_range(0, 255));
      end
      run_job($sformatf("rand%0d", r), mk(ra, rb, model(ra, rb), 0, m4(0,0,0,0), m4(0,0,0,0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pim_matmul_engine.md
Name: pim_matmul_engine

Overview:
- Responder side of the memory-to-PIM compute handshake.
- Accepts a start pulse/level with two row-major N×N operand matrices.
- Computes C = A×B sequentially with one multiply-accumulate per cycle, then signals completion with result_ready.
- Sits under the memory block: the memory block drives start, matrix_A and matrix_B, waits for result_ready, then writes result back.

Parameters:
- DATA_W, default WIDTH (types package), element width in bits.
- N, default MATRIX_SIZE (types package), matrix dimension.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  level; sampled only in IDLE
- matrix_A  input  [DATA_W-1:0] x N*N  operand A, row-major, element i = A[i/N][i%N]
- matrix_B  input  [DATA_W-1:0] x N*N  operand B, row-major
- result  output  [DATA_W-1:0] x N*N  product C, row-major
- result_ready  output  1  high for exactly one cycle when result is complete
- busy  output  1  high in LOAD-free COMPUTE and DONE states (not IDLE)

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset, including mid-operation:
  - state=IDLE; row/col/k counters=0; accumulator=0.
  - all result elements=0; result_ready=0; busy=0.
  - Any in-flight computation is discarded.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - On an edge with start=1: copy matrix_A/matrix_B into internal operand registers, clear counters and accumulator, go to COMPUTE.
  - Operands are read only at this edge; later changes to the inputs are ignored.
- COMPUTE: one MAC per cycle.
  - acc_next = acc + opA[row*N+k] * opB[k*N+col].
  - When k=N-1: write acc_next to result[row*N+col], clear acc, k=0, advance col; on col wrap advance row.
  - After element (N-1,N-1) is written, go to DONE.
  - Total: exactly N^3 edges in COMPUTE.
- DONE: result_ready=1 and busy=1 for this single cycle; next edge to IDLE.
- Latency: result_ready is high in the cycle after N^3+1 rising edges following the start-sampling edge (N=2: edge 0 samples start, ready during cycle after edge 9).
- Arithmetic:
  - Product and sum are truncated to DATA_W bits (modulo 2^DATA_W).
  - Unsigned; no saturation; no overflow flag.
- result:
  - Element written only in COMPUTE at its final k.
  - Holds its value through DONE and IDLE until overwritten by the next job. The memory block therefore may sample it any time after result_ready.
- start while busy (COMPUTE/DONE): ignored, no queueing.
- start still high when returning to IDLE: a new job begins on the first IDLE edge with start=1 (level semantics). The initiator must deassert start after one cycle to avoid a re-run.
- result_ready is derived from the registered state only; no combinational path from any input.

Decomposition:
- types package: WIDTH, MATRIX_SIZE, LEN, MEM_ELEMENTS (existing), plus new pim_state_t enum {IDLE, COMPUTE, DONE}.
- Counter widths: $clog2(N) with minimum 1, defined as a package localparam.
- One sub-module: pim_mac_unit.
  - Holds the DATA_W accumulator register.
  - Inputs: clr, en, a, b.
  - Outputs: acc_next (combinational) and acc.
- The engine owns the FSM, counters, operand registers and result array.

Test Plan (N=2 unless stated):
- Basic product: A=[1,2,3,4], B=[5,6,7,8], start pulsed 1 cycle -> result=[19,22,43,50]; result_ready high exactly one cycle, in the cycle after edge 9; busy high from edge 1 to edge 9.
- Identity: A=[1,0,0,1], B=[9,8,7,6] -> result=[9,8,7,6]; a second job with A=[2,0,0,2] -> [18,16,14,12], with previous result held until overwritten.
- Wrap (DATA_W=8): A and B all 255 -> every result element = 2 ((65025+65025) mod 256).
- Busy collision: pulse start again at edge 4 with different operands -> ignored; result still [19,22,43,50]; only one result_ready pulse.
- Reset mid-compute: assert rst at edge 5 for one cycle -> result all 0, busy=0, no result_ready; a fresh start then yields a correct product at normal latency.
- Operand change after start: change matrix_A inputs at edge 2 -> result unaffected (operands latched at start edge).
